// File: rtl/decode_misc_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_misc_mem_pkg
//  Brief    : Shared types and encodings for the MISC-MEM decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package decode_misc_mem_pkg;

    typedef enum logic [2:0] {
        fk_invalid   = 3'd0,
        fk_fence     = 3'd1,
        fk_fence_i   = 3'd2,
        fk_fence_tso = 3'd3,
        fk_pause     = 3'd4
    } fence_kind_t;

    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [3:0] FM_NORMAL    = 4'b0000;
    localparam logic [3:0] FM_TSO       = 4'b1000;
    localparam logic [2:0] F3_FENCE     = 3'b000;
    localparam logic [2:0] F3_FENCE_I   = 3'b001;

    typedef struct packed {
        fence_kind_t kind;
        logic [3:0]  pred;
        logic [3:0]  succ;
        logic        illegal;
    } lane_dec_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/decode_misc_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : decode_misc_mem_if
//  Brief    : Input bundle / decoded output handshake bus of the decoder.
//  Revision : 1.0 - initial release
// ============================================================================
interface decode_misc_mem_if #(
    parameter int LANES = 2
);
    import decode_misc_mem_pkg::*;

    logic                          in_valid;
    logic                          in_ready;
    logic [LANES-1:0]              in_lane_valid;
    logic [32*LANES-1:0]           in_instr;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES-1:0]              out_lane_valid;
    fence_kind_t [LANES-1:0]       out_kind;
    logic [4*LANES-1:0]            out_pred;
    logic [4*LANES-1:0]            out_succ;
    logic [LANES-1:0]              out_illegal;

    modport slave (
        input  in_valid, in_lane_valid, in_instr, out_ready,
        output in_ready, out_valid, out_lane_valid, out_kind,
               out_pred, out_succ, out_illegal
    );

    modport master (
        output in_valid, in_lane_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_lane_valid, out_kind,
               out_pred, out_succ, out_illegal
    );

endinterface
`default_nettype wire

// File: rtl/decode_misc_mem_lane.sv
`default_nettype none
// ============================================================================
//  Module   : decode_misc_mem_lane
//  Brief    : Combinational decode of one 32-bit word as a MISC-MEM instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_misc_mem_lane
    import decode_misc_mem_pkg::*;
#(
    parameter bit ENABLE_FENCE_I = 1'b1,
    parameter bit ENABLE_TSO     = 1'b1
) (
    input  logic        i_lane_valid,
    input  logic [31:0] i_instr,
    output lane_dec_t   o_dec
);

    logic [6:0] w_opcode;
    logic [4:0] w_rd;
    logic [2:0] w_funct3;
    logic [4:0] w_rs1;
    logic [3:0] w_succ;
    logic [3:0] w_pred;
    logic [3:0] w_fm;

    assign w_opcode = i_instr[6:0];
    assign w_rd     = i_instr[11:7];
    assign w_funct3 = i_instr[14:12];
    assign w_rs1    = i_instr[19:15];
    assign w_succ   = i_instr[23:20];
    assign w_pred   = i_instr[27:24];
    assign w_fm     = i_instr[31:28];

    always_comb begin
        o_dec.kind    = fk_invalid;
        o_dec.pred    = 4'b0000;
        o_dec.succ    = 4'b0000;
        o_dec.illegal = 1'b0;
        if (i_lane_valid) begin
            if (w_opcode != OPC_MISC_MEM) begin
                o_dec.illegal = 1'b1;
            end else begin
                case (w_funct3)
                    F3_FENCE: begin
                        if (w_fm == FM_TSO && w_pred == 4'b0011 && w_succ == 4'b0011) begin
                            // Without TSO support the safe fallback is a full fence.
                            if (ENABLE_TSO) begin
                                o_dec.kind = fk_fence_tso;
                                o_dec.pred = 4'b0011;
                                o_dec.succ = 4'b0011;
                            end else begin
                                o_dec.kind = fk_fence;
                                o_dec.pred = 4'b1111;
                                o_dec.succ = 4'b1111;
                            end
                        end else if (w_fm == FM_NORMAL && w_pred == 4'b0001 && w_succ == 4'b0000
                                     && w_rs1 == 5'd0 && w_rd == 5'd0) begin
                            o_dec.kind = fk_pause;
                            o_dec.pred = 4'b0001;
                        end else begin
                            o_dec.kind = fk_fence;
                            o_dec.pred = w_pred;
                            o_dec.succ = w_succ;
                        end
                    end
                    F3_FENCE_I: begin
                        if (ENABLE_FENCE_I) begin
                            o_dec.kind = fk_fence_i;
                        end else begin
                            o_dec.illegal = 1'b1;
                        end
                    end
                    default: o_dec.illegal = 1'b1;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_misc_mem.sv
`default_nettype none
// ============================================================================
//  Module   : decode_misc_mem
//  Brief    : Multi-lane MISC-MEM decoder behind a registered 2-entry skid buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_misc_mem
    import decode_misc_mem_pkg::*;
#(
    parameter int LANES          = 2,
    parameter bit ENABLE_FENCE_I = 1'b1,
    parameter bit ENABLE_TSO     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    decode_misc_mem_if.slave     bus
);

    lane_dec_t [LANES-1:0] w_dec;
    lane_dec_t [LANES-1:0] r_m_dec;
    lane_dec_t [LANES-1:0] r_s_dec;
    logic [LANES-1:0]      r_m_lv;
    logic [LANES-1:0]      r_s_lv;

    buf_state_t r_state;
    buf_state_t w_state_nxt;
    logic       r_in_ready;
    logic       r_out_valid;
    logic       w_accept;
    logic       w_pop;
    logic       w_load_m;
    logic       w_load_s;
    logic       w_shift;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        decode_misc_mem_lane #(
            .ENABLE_FENCE_I (ENABLE_FENCE_I),
            .ENABLE_TSO     (ENABLE_TSO)
        ) u_lane (
            .i_lane_valid (bus.in_lane_valid[i]),
            .i_instr      (bus.in_instr[32*i +: 32]),
            .o_dec        (w_dec[i])
        );
    end

    assign w_accept = bus.in_valid & r_in_ready & ~flush;
    assign w_pop    = r_out_valid & bus.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load_m    = 1'b0;
        w_load_s    = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_load_m    = 1'b1;
                end
            end
            ST_ONE: begin
                case ({w_accept, w_pop})
                    2'b10: begin
                        w_state_nxt = ST_TWO;
                        w_load_s    = 1'b1;
                    end
                    2'b01:   w_state_nxt = ST_EMPTY;
                    2'b11:   w_load_m    = 1'b1;
                    default: w_state_nxt = ST_ONE;
                endcase
            end
            ST_TWO: begin
                if (w_pop) begin
                    w_state_nxt = ST_ONE;
                    w_shift     = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_load_m    = 1'b0;
            w_load_s    = 1'b0;
            w_shift     = 1'b0;
        end
    end

    // Handshake flags are registered from the next state so neither output
    // has a combinational path from in_valid or out_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_dec <= '0;
            r_m_lv  <= '0;
            r_s_dec <= '0;
            r_s_lv  <= '0;
        end else begin
            if (w_load_m) begin
                r_m_dec <= w_dec;
                r_m_lv  <= bus.in_lane_valid;
            end else if (w_shift) begin
                r_m_dec <= r_s_dec;
                r_m_lv  <= r_s_lv;
            end
            if (w_load_s) begin
                r_s_dec <= w_dec;
                r_s_lv  <= bus.in_lane_valid;
            end
        end
    end

    assign bus.in_ready       = r_in_ready;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_lane_valid = r_m_lv;

    for (genvar i = 0; i < LANES; i++) begin : g_out
        assign bus.out_kind[i]        = r_m_dec[i].kind;
        assign bus.out_pred[4*i +: 4] = r_m_dec[i].pred;
        assign bus.out_succ[4*i +: 4] = r_m_dec[i].succ;
        assign bus.out_illegal[i]     = r_m_dec[i].illegal;
    end

endmodule
`default_nettype wire
